// File: rtl/spi_cmd_sequencer.sv
// rtl/spi_cmd_sequencer.sv - command FIFO and issue/response sequencer in front of the SPI master
module spi_cmd_sequencer #(
  parameter int FIFO_AW   = 2,
  parameter int BUSY_WAIT = 4,
  parameter int TIMEOUT   = 1000
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic               cmd_rw,
  input  logic [7:0]         cmd_addr,
  input  logic [7:0]         cmd_wdata,
  output logic               rsp_valid,
  output logic [7:0]         rsp_addr,
  output logic [7:0]         rsp_data,
  output logic               rsp_err,
  output logic               err_timeout,
  input  logic               err_clr,
  output logic [FIFO_AW:0]   fifo_level,
  output logic               spi_wr_en,
  output logic               spi_re_en,
  output logic [7:0]         spi_addr,
  output logic [7:0]         spi_send_data,
  input  logic [7:0]         spi_read_data,
  input  logic               spi_busy,
  input  logic               spi_over
);

  localparam int DEPTH = 2 ** FIFO_AW;
  localparam logic [FIFO_AW:0] FULL_LVL = (FIFO_AW + 1)'(DEPTH);

  typedef enum logic [2:0] {IDLE, ISSUE, WAIT_BUSY, WAIT_OVER, CAPTURE, ERR} state_t;

  state_t             state, next_state;
  logic [15:0]        timer;
  logic [16:0]        fifo_mem [DEPTH];
  logic [FIFO_AW-1:0] wr_ptr, rd_ptr;
  logic [FIFO_AW:0]   level;
  logic               push, pop;
  logic               cur_rw;
  logic [7:0]         cur_addr, cur_wdata;

  assign cmd_ready     = (level != FULL_LVL);
  assign push          = cmd_valid && cmd_ready;
  assign fifo_level    = level;
  assign spi_addr      = cur_addr;
  assign spi_send_data = cur_wdata;

  // timer restarts on every state change
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      timer <= 16'd0;
    end else begin
      state <= next_state;
      timer <= (next_state != state) ? 16'd0 : timer + 16'd1;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:      if (level != '0 && !spi_busy) next_state = ISSUE;
      ISSUE:     next_state = WAIT_BUSY;
      WAIT_BUSY: begin
        if (spi_busy) next_state = WAIT_OVER;
        else if (timer == 16'(BUSY_WAIT - 1)) next_state = ERR;
      end
      WAIT_OVER: begin
        if (spi_over) next_state = cur_rw ? CAPTURE : IDLE;
        else if (timer == 16'(TIMEOUT - 1)) next_state = ERR;
      end
      CAPTURE:   next_state = IDLE;
      ERR:       next_state = IDLE;
      default:   next_state = IDLE;
    endcase
  end

  always_comb begin
    pop       = (state == IDLE) && (level != '0) && !spi_busy;
    spi_wr_en = (state == ISSUE) && !cur_rw;
    spi_re_en = (state == ISSUE) && cur_rw;
  end

  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= {cmd_rw, cmd_addr, cmd_wdata};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      level       <= '0;
      cur_rw      <= 1'b0;
      cur_addr    <= 8'h00;
      cur_wdata   <= 8'h00;
      rsp_valid   <= 1'b0;
      rsp_addr    <= 8'h00;
      rsp_data    <= 8'h00;
      rsp_err     <= 1'b0;
      err_timeout <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + FIFO_AW'(1);
      if (pop) begin
        rd_ptr                          <= rd_ptr + FIFO_AW'(1);
        {cur_rw, cur_addr, cur_wdata}   <= fifo_mem[rd_ptr];
      end
      case ({push, pop})
        2'b10:   level <= level + (FIFO_AW + 1)'(1);
        2'b01:   level <= level - (FIFO_AW + 1)'(1);
        default: level <= level;
      endcase

      rsp_valid <= (state == CAPTURE) || (state == ERR && cur_rw);
      if (state == CAPTURE) begin
        rsp_data <= spi_read_data;
        rsp_addr <= cur_addr;
        rsp_err  <= 1'b0;
      end else if (state == ERR && cur_rw) begin
        rsp_data <= 8'hFF;
        rsp_addr <= cur_addr;
        rsp_err  <= 1'b1;
      end

      // a timeout in the same cycle as err_clr keeps the flag set
      if (state == ERR) err_timeout <= 1'b1;
      else if (err_clr) err_timeout <= 1'b0;
    end
  end

endmodule

// File: tb/tb_spi_cmd_sequencer.sv
// tb/tb_spi_cmd_sequencer.sv - directed self-checking bench for spi_cmd_sequencer
module tb_spi_cmd_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic       cmd_valid, cmd_ready, cmd_rw;
  logic [7:0] cmd_addr, cmd_wdata;
  logic       rsp_valid, rsp_err, err_timeout, err_clr;
  logic [7:0] rsp_addr, rsp_data;
  logic [2:0] fifo_level;
  logic       spi_wr_en, spi_re_en, spi_busy, spi_over;
  logic [7:0] spi_addr, spi_send_data, spi_read_data;

  int checks = 0;
  int errors = 0;
  int rsp_cnt = 0, wr_cnt = 0, re_cnt = 0, both_cnt = 0, b2b_cnt = 0;
  logic prev_rsp = 1'b0;

  always #5 clk = ~clk;

  spi_cmd_sequencer dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_rw(cmd_rw),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_addr(rsp_addr), .rsp_data(rsp_data), .rsp_err(rsp_err),
    .err_timeout(err_timeout), .err_clr(err_clr), .fifo_level(fifo_level),
    .spi_wr_en(spi_wr_en), .spi_re_en(spi_re_en), .spi_addr(spi_addr),
    .spi_send_data(spi_send_data), .spi_read_data(spi_read_data),
    .spi_busy(spi_busy), .spi_over(spi_over)
  );

  // pulse bookkeeping, compared against hand counts at the end
  always @(negedge clk) begin
    if (!rst) begin
      if (rsp_valid) rsp_cnt++;
      if (rsp_valid && prev_rsp) b2b_cnt++;
      if (spi_wr_en) wr_cnt++;
      if (spi_re_en) re_cnt++;
      if (spi_wr_en && spi_re_en) both_cnt++;
    end
    prev_rsp = rsp_valid;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=no_finish expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic rw, input logic [7:0] a, input logic [7:0] d);
    cmd_valid = 1'b1; cmd_rw = rw; cmd_addr = a; cmd_wdata = d;
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  // wait for the issue pulse, then play a well-behaved master
  task automatic xfer(input logic rw, input logic [7:0] a, input logic [7:0] d, input logic [7:0] rd);
    int n = 0;
    @(negedge clk);
    while (!(spi_wr_en || spi_re_en) && n < 8) begin
      @(negedge clk);
      n++;
    end
    chk("issue_seen", 16'(spi_wr_en | spi_re_en), 16'h1);
    chk("issue_kind", 16'({spi_re_en, spi_wr_en}), rw ? 16'h2 : 16'h1);
    chk("issue_addr", 16'(spi_addr), 16'(a));
    if (!rw) chk("issue_data", 16'(spi_send_data), 16'(d));
    @(negedge clk);
    chk("en_one_cycle", 16'({spi_re_en, spi_wr_en}), 16'h0);
    spi_busy = 1'b1;
    @(negedge clk);
    chk("addr_held", 16'(spi_addr), 16'(a));
    spi_over = 1'b1;
    @(negedge clk);
    spi_over = 1'b0;
    spi_busy = 1'b0;
    if (rw) begin
      spi_read_data = rd;
      chk("rsp_not_early", 16'(rsp_valid), 16'h0);
      @(negedge clk);
      chk("rsp_valid", 16'(rsp_valid), 16'h1);
      chk("rsp_addr", 16'(rsp_addr), 16'(a));
      chk("rsp_data", 16'(rsp_data), 16'(rd));
      chk("rsp_err", 16'(rsp_err), 16'h0);
      @(negedge clk);
      chk("rsp_pulse", 16'(rsp_valid), 16'h0);
    end
  endtask

  initial begin
    rst = 1'b1; cmd_valid = 1'b0; cmd_rw = 1'b0; cmd_addr = 8'h00; cmd_wdata = 8'h00;
    err_clr = 1'b0; spi_read_data = 8'h00; spi_busy = 1'b0; spi_over = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_level", 16'(fifo_level), 16'h0);
    chk("rst_ready", 16'(cmd_ready), 16'h1);
    chk("rst_outs", 16'({rsp_valid, rsp_err, err_timeout, spi_wr_en, spi_re_en}), 16'h0);
    chk("rst_bus", {spi_addr, spi_send_data}, 16'h0000);
    rst = 1'b0;
    @(negedge clk);

    // single write
    push(1'b0, 8'h12, 8'h34);
    chk("w_level1", 16'(fifo_level), 16'h1);
    xfer(1'b0, 8'h12, 8'h34, 8'h00);
    chk("w_level0", 16'(fifo_level), 16'h0);

    // single read
    push(1'b1, 8'h40, 8'h00);
    xfer(1'b1, 8'h40, 8'h00, 8'hA5);

    // fill while master busy, fifth push refused, then drain in order
    spi_busy = 1'b1;
    for (int i = 0; i < 4; i++) push(1'b0, 8'h60 + 8'(i), 8'hB0 + 8'(i));
    chk("full_level", 16'(fifo_level), 16'h4);
    chk("full_ready", 16'(cmd_ready), 16'h0);
    cmd_valid = 1'b1; cmd_rw = 1'b0; cmd_addr = 8'h64; cmd_wdata = 8'hB4;
    @(negedge clk);
    chk("full_refuse", 16'(fifo_level), 16'h4);
    cmd_valid = 1'b0;
    spi_busy = 1'b0;
    for (int i = 0; i < 4; i++) xfer(1'b0, 8'h60 + 8'(i), 8'hB0 + 8'(i), 8'h00);
    chk("drain_level", 16'(fifo_level), 16'h0);

    // write that never sees busy: timeout, no response
    push(1'b0, 8'h70, 8'h55);
    @(negedge clk);
    chk("tw_issue", 16'(spi_wr_en), 16'h1);
    repeat (5) @(negedge clk);
    chk("tw_err_pending", 16'(err_timeout), 16'h0);
    @(negedge clk);
    chk("tw_err_set", 16'(err_timeout), 16'h1);
    chk("tw_no_rsp", 16'(rsp_valid), 16'h0);

    // read that never sees busy: error response
    push(1'b1, 8'h71, 8'h00);
    @(negedge clk);
    chk("tr_issue", 16'(spi_re_en), 16'h1);
    repeat (5) @(negedge clk);
    chk("tr_rsp_pending", 16'(rsp_valid), 16'h0);
    @(negedge clk);
    chk("tr_rsp_valid", 16'(rsp_valid), 16'h1);
    chk("tr_rsp_err", 16'(rsp_err), 16'h1);
    chk("tr_rsp_data", 16'(rsp_data), 16'h00FF);
    chk("tr_rsp_addr", 16'(rsp_addr), 16'h0071);
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    chk("err_cleared", 16'(err_timeout), 16'h0);

    // full FIFO with a refused push coinciding with a pop
    spi_busy = 1'b1;
    for (int i = 0; i < 4; i++) push(1'b0, 8'h80 + 8'(i), 8'hC0 + 8'(i));
    chk("pp_full", 16'(fifo_level), 16'h4);
    cmd_valid = 1'b1; cmd_rw = 1'b0; cmd_addr = 8'h99; cmd_wdata = 8'h99;
    spi_busy = 1'b0;
    @(negedge clk);
    cmd_valid = 1'b0;
    chk("pp_level", 16'(fifo_level), 16'h3);
    chk("pp_ready", 16'(cmd_ready), 16'h1);
    chk("pp_issue", 16'(spi_wr_en), 16'h1);
    chk("pp_head", 16'(spi_addr), 16'h0080);
    @(negedge clk);
    spi_busy = 1'b1;
    @(negedge clk);
    // now in WAIT_OVER: reset abandons the command
    rst = 1'b1;
    @(negedge clk);
    chk("mr_level", 16'(fifo_level), 16'h0);
    chk("mr_outs", 16'({rsp_valid, rsp_err, err_timeout, spi_wr_en, spi_re_en}), 16'h0);
    chk("mr_bus", {spi_addr, spi_send_data}, 16'h0000);
    chk("mr_rsp", {rsp_addr, rsp_data}, 16'h0000);
    rst = 1'b0;
    spi_busy = 1'b0;
    repeat (4) @(negedge clk);
    chk("mr_idle", 16'({spi_wr_en, spi_re_en, rsp_valid}), 16'h0);
    chk("mr_level_after", 16'(fifo_level), 16'h0);

    @(negedge clk);
    chk("cnt_rsp", 16'(rsp_cnt), 16'd2);
    chk("cnt_wr", 16'(wr_cnt), 16'd7);
    chk("cnt_re", 16'(re_cnt), 16'd2);
    chk("cnt_both", 16'(both_cnt), 16'd0);
    chk("cnt_b2b", 16'(b2b_cnt), 16'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
